// File: rtl/retire_trace_pkg.sv
// Shared types and defaults for the retirement trace monitor.
// The record layout is fixed at 32-bit PC/data and 16-bit sequence numbers.
package retire_trace_pkg;

  localparam int REC_XLEN = 32;
  localparam int REC_SEQW = 16;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000000c;
  localparam logic [31:0] HALT_V0_DEFAULT    = 32'h0000000a;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [REC_XLEN-1:0] instr;
    logic                wen;
    logic [4:0]          rd;
    logic [REC_XLEN-1:0] wdata;
    logic [REC_SEQW-1:0] seq;
  } retire_rec_t;

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// In-order record FIFO: up to LANES pushes and one pop per cycle.
// The caller guarantees pushes never exceed free space plus the same-cycle pop.
module trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LANES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(LANES+1)-1:0]    push_cnt,
  input  retire_rec_t [LANES-1:0]       push_data,
  input  logic                          pop,
  output retire_rec_t                   head,
  output logic [$clog2(DEPTH):0]        level,
  output logic [$clog2(DEPTH):0]        free
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  retire_rec_t       mem_q [DEPTH];
  retire_rec_t       mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     idx;
  logic [LW-1:0]     level_q, level_d;

  // Lane i lands at wr+i; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    idx   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(push_cnt)) begin
        idx        = wr_q + AW'(i);
        mem_d[idx] = push_data[i];
      end
    end
    wr_d    = wr_q + AW'(push_cnt);
    rd_d    = rd_q + AW'(pop);
    level_d = level_q + LW'(push_cnt) - LW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign level = level_q;
  assign free  = LW'(DEPTH) - level_q;

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement monitor: filters WB retires, queues them with sequence numbers,
// detects the end-of-test syscall and runs a retirement watchdog.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int              XLEN       = REC_XLEN,
  parameter int              DEPTH      = 16,
  parameter int              LANES      = 1,
  parameter int              SEQW       = REC_SEQW,
  parameter int              TIMEOUT    = 1024,
  parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter logic [XLEN-1:0] HALT_V0    = HALT_V0_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        ret_valid,
  input  logic [LANES*XLEN-1:0]   ret_pc,
  input  logic [LANES*XLEN-1:0]   ret_instr,
  input  logic [LANES-1:0]        ret_wen,
  input  logic [LANES*5-1:0]      ret_rd,
  input  logic [LANES*XLEN-1:0]   ret_wdata,
  input  logic [XLEN-1:0]         halt_v0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_instr,
  output logic [XLEN-1:0]         out_wdata,
  output logic [4:0]              out_rd,
  output logic                    out_wen,
  output logic [SEQW-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]  level,
  output logic [31:0]             retired_count,
  output logic                    overflow,
  output logic                    timeout,
  output logic                    done
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int PCW = $clog2(LANES + 1);
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [SEQW-1:0]         seq_q, seq_d;
  logic [31:0]             count_q, count_d;
  logic [32:0]             count_sum;
  logic                    overflow_q, overflow_d;
  logic                    timeout_q, timeout_d;
  logic [WDW-1:0]          wd_q, wd_d;
  logic                    last_valid_q, last_valid_d;
  logic [XLEN-1:0]         last_pc_q, last_pc_d;
  logic [XLEN-1:0]         last_instr_q, last_instr_d;
  logic [XLEN-1:0]         lane_pc, lane_instr;
  logic [PCW-1:0]          push_cnt;
  retire_rec_t [LANES-1:0] push_data;
  retire_rec_t             head;
  logic [LW-1:0]           free, room;
  logic                    pop, halt_hit;
  int                      n;

  assign pop  = out_valid & out_ready;
  assign room = free + LW'(pop);

  // last_*_d doubles as the running "previous record" so lane 1 is judged against lane 0.
  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;
    wd_d         = wd_q;
    last_valid_d = last_valid_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    lane_pc      = '0;
    lane_instr   = '0;
    push_data    = '0;
    halt_hit     = 1'b0;
    n            = 0;
    for (int l = 0; l < LANES; l++) begin
      lane_pc    = ret_pc[l*XLEN +: XLEN];
      lane_instr = ret_instr[l*XLEN +: XLEN];
      if (state_q == RUN && !halt_hit && ret_valid[l] && lane_instr != '0 &&
          !(last_valid_d && lane_pc == last_pc_d && lane_instr == last_instr_d)) begin
        last_valid_d = 1'b1;
        last_pc_d    = lane_pc;
        last_instr_d = lane_instr;
        if (n < int'(room)) begin
          push_data[n].pc    = lane_pc;
          push_data[n].instr = lane_instr;
          push_data[n].wen   = ret_wen[l];
          push_data[n].rd    = ret_rd[l*5 +: 5];
          push_data[n].wdata = ret_wdata[l*XLEN +: XLEN];
          push_data[n].seq   = seq_q + SEQW'(n);
          n = n + 1;
          if (lane_instr == HALT_INSTR && halt_v0 == HALT_V0) begin
            halt_hit = 1'b1;
          end
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
    push_cnt  = PCW'(n);
    seq_d     = seq_q + SEQW'(n);
    count_sum = {1'b0, count_q} + 33'(push_cnt);
    count_d   = count_sum[32] ? '1 : count_sum[31:0];

    case (state_q)
      RUN:     if (halt_hit) state_d = DRAIN;
      DRAIN:   if (level == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase

    if (TIMEOUT != 0 && state_q == RUN) begin
      if (push_cnt != '0) begin
        wd_d = '0;
      end else if (wd_q != WD_MAX) begin
        wd_d = wd_q + 1'b1;
      end
      if (wd_d == WD_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      seq_q        <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
      last_valid_q <= 1'b0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
      last_valid_q <= last_valid_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .free      (free)
  );

  assign out_valid     = (level != '0);
  assign out_pc        = head.pc;
  assign out_instr     = head.instr;
  assign out_wdata     = head.wdata;
  assign out_rd        = head.rd;
  assign out_wen       = head.wen;
  assign out_seq       = head.seq;
  assign retired_count = count_q;
  assign overflow      = overflow_q;
  assign timeout       = timeout_q;
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized and directed bench for retire_trace_buffer against a queue-based
// reference model that follows the monitor's rules record by record.
module tb_retire_trace_buffer;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int LANES   = 2;
  localparam int SEQW    = 16;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] HALT_I = 32'h0000000c;
  localparam logic [31:0] HALT_A = 32'h0000000a;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [LANES-1:0]       ret_valid = '0;
  logic [LANES*XLEN-1:0]  ret_pc = '0;
  logic [LANES*XLEN-1:0]  ret_instr = '0;
  logic [LANES-1:0]       ret_wen = '0;
  logic [LANES*5-1:0]     ret_rd = '0;
  logic [LANES*XLEN-1:0]  ret_wdata = '0;
  logic [XLEN-1:0]        halt_v0 = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [XLEN-1:0]        out_pc, out_instr, out_wdata;
  logic [4:0]             out_rd;
  logic                   out_wen;
  logic [SEQW-1:0]        out_seq;
  logic [$clog2(DEPTH):0] level;
  logic [31:0]            retired_count;
  logic                   overflow, timeout, done;

  always #5 clk = ~clk;

  retire_trace_buffer #(
    .XLEN (XLEN), .DEPTH (DEPTH), .LANES (LANES), .SEQW (SEQW), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .reset (reset),
    .ret_valid (ret_valid), .ret_pc (ret_pc), .ret_instr (ret_instr),
    .ret_wen (ret_wen), .ret_rd (ret_rd), .ret_wdata (ret_wdata),
    .halt_v0 (halt_v0),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_pc (out_pc), .out_instr (out_instr), .out_wdata (out_wdata),
    .out_rd (out_rd), .out_wen (out_wen), .out_seq (out_seq),
    .level (level), .retired_count (retired_count),
    .overflow (overflow), .timeout (timeout), .done (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of records plus the monitor's bookkeeping.
  typedef struct {
    logic [31:0] pc, instr, wdata;
    logic        wen;
    logic [4:0]  rd;
    logic [15:0] seq;
  } mrec_t;

  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  mrec_t       mq[$];
  int          m_state;
  int          m_seq;
  longint      m_count;
  bit          m_ovf, m_to;
  int          m_idle;
  bit          m_last_valid;
  logic [31:0] m_last_pc, m_last_instr;

  task automatic modelReset();
    mq.delete();
    m_state = M_RUN; m_seq = 0; m_count = 0; m_ovf = 0; m_to = 0; m_idle = 0;
    m_last_valid = 0; m_last_pc = 0; m_last_instr = 0;
  endtask

  task automatic modelStep();
    int pre, stored;
    bit halt;
    logic [31:0] pc, ins;
    mrec_t r;
    pre = mq.size(); stored = 0; halt = 0;
    if (pre > 0 && out_ready) void'(mq.pop_front());
    if (m_state == M_RUN) begin
      for (int l = 0; l < LANES; l++) begin
        pc  = ret_pc[l*32 +: 32];
        ins = ret_instr[l*32 +: 32];
        if (!ret_valid[l] || ins == 0 || halt) continue;
        if (m_last_valid && pc == m_last_pc && ins == m_last_instr) continue;
        m_last_valid = 1; m_last_pc = pc; m_last_instr = ins;
        if (mq.size() >= DEPTH) begin
          m_ovf = 1;
          continue;
        end
        r.pc = pc; r.instr = ins; r.wdata = ret_wdata[l*32 +: 32];
        r.wen = ret_wen[l]; r.rd = ret_rd[l*5 +: 5]; r.seq = 16'(m_seq);
        mq.push_back(r);
        m_seq = (m_seq + 1) % 65536;
        stored++;
        if (ins == HALT_I && halt_v0 == HALT_A) halt = 1;
      end
      if (stored > 0) m_idle = 0;
      else if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT) m_to = 1;
      if (halt) m_state = M_DRAIN;
    end else if (m_state == M_DRAIN && pre == 0) begin
      m_state = M_DONE;
    end
    m_count = m_count + stored;
    if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
  endtask

  task automatic compareAll();
    checkOutput("out_valid", out_valid, mq.size() != 0);
    checkOutput("level", level, mq.size());
    checkOutput("retired_count", retired_count, m_count);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("timeout", timeout, m_to);
    checkOutput("done", done, m_state == M_DONE);
    if (mq.size() != 0) begin
      checkOutput("out_pc", out_pc, mq[0].pc);
      checkOutput("out_instr", out_instr, mq[0].instr);
      checkOutput("out_wdata", out_wdata, mq[0].wdata);
      checkOutput("out_wen", out_wen, mq[0].wen);
      checkOutput("out_rd", out_rd, mq[0].rd);
      checkOutput("out_seq", out_seq, mq[0].seq);
    end
  endtask

  // Drive one cycle of lane inputs, step the model, and compare after the edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                               input logic [31:0] pc1, input logic [31:0] i1,
                               input logic rdy, input logic [31:0] v0);
    ret_valid = v;
    ret_pc    = {pc1, pc0};
    ret_instr = {i1, i0};
    ret_wen   = 2'($urandom);
    ret_rd    = 10'($urandom);
    ret_wdata = {$urandom, $urandom};
    out_ready = rdy;
    halt_v0   = v0;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(2'b00, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic doReset();
    ret_valid = '0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compareAll();
  endtask

  initial begin
    #3;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single-lane consecutive retires, consumer always ready.
    applyStimulus(2'b01, 32'h00, 32'h20020001, 0, 0, 1, 0);
    checkOutput("seq_first", out_seq, 0);
    applyStimulus(2'b01, 32'h04, 32'h20020002, 0, 0, 1, 0);
    checkOutput("seq_second", out_seq, 1);
    applyStimulus(2'b01, 32'h08, 32'h20020003, 0, 0, 1, 0);
    checkOutput("seq_third", out_seq, 2);
    idle(1);
    checkOutput("count_three", retired_count, 3);

    // Stall repeats and bubbles collapse into one record.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(2'b01, 32'h04, 32'h20020005, 0, 0, 0, 0);
    applyStimulus(2'b01, 32'h08, 32'h0, 0, 0, 0, 0);
    applyStimulus(2'b11, 32'h04, 32'h20020005, 32'h0c, 32'h0, 0, 0);
    checkOutput("stall_count", retired_count, 1);

    // Overflow with a stalled consumer, then an in-order drain.
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(2'b01, 32'(k * 4), 32'h20020100 + 32'(k), 0, 0, 0, 0);
    checkOutput("ovf_level", level, 4);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_count", retired_count, 4);
    for (int k = 0; k < 5; k++) idle(1);

    // Two lanes in one cycle: lane 0 first.
    doReset();
    applyStimulus(2'b11, 32'h10, 32'h20020010, 32'h14, 32'h20020014, 0, 0);
    checkOutput("dual_level", level, 2);
    checkOutput("dual_head_pc", out_pc, 32'h10);
    applyStimulus(2'b00, 0, 0, 0, 0, 1, 0);
    checkOutput("dual_second_pc", out_pc, 32'h14);

    // Halt with queued entries, later retires ignored, then drain to done.
    doReset();
    applyStimulus(2'b01, 32'h20, 32'h20020020, 0, 0, 0, 0);
    applyStimulus(2'b01, 32'h24, 32'h20020024, 0, 0, 0, 0);
    applyStimulus(2'b11, 32'h28, HALT_I, 32'h2c, 32'h2002002c, 0, HALT_A);
    checkOutput("halt_level", level, 3);
    applyStimulus(2'b01, 32'h30, 32'h20020030, 0, 0, 0, 0);
    checkOutput("drain_ignores", level, 3);
    for (int k = 0; k < 10 && m_state != M_DONE; k++) idle(1);
    checkOutput("halt_done", done, 1);
    idle(1);

    // Halt encoding with the wrong $v0 is an ordinary record.
    doReset();
    applyStimulus(2'b01, 32'h40, HALT_I, 0, 0, 0, 32'h3);
    applyStimulus(2'b01, 32'h44, 32'h20020044, 0, 0, 0, 32'h3);
    checkOutput("nohalt_level", level, 2);

    // Watchdog fires after TIMEOUT idle cycles and stays set.
    doReset();
    for (int k = 0; k < TIMEOUT - 1; k++) idle(0);
    checkOutput("timeout_early", timeout, 0);
    idle(0);
    checkOutput("timeout_fire", timeout, 1);
    applyStimulus(2'b01, 32'h50, 32'h20020050, 0, 0, 0, 0);
    checkOutput("timeout_sticky", timeout, 1);

    // Reset in the middle of a drain.
    doReset();
    applyStimulus(2'b01, 32'h60, 32'h20020060, 0, 0, 0, 0);
    applyStimulus(2'b01, 32'h64, HALT_I, 0, 0, 0, HALT_A);
    idle(0);
    doReset();
    checkOutput("midreset_level", level, 0);
    checkOutput("midreset_done", done, 0);
    applyStimulus(2'b01, 32'h68, 32'h20020068, 0, 0, 0, 0);
    checkOutput("midreset_run", level, 1);

    // Random traffic with a small PC/instr pool so duplicates and halts occur.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] p0, p1, n0, n1;
      if (m_state == M_DONE || $urandom_range(0, 199) == 0) doReset();
      p0 = 32'($urandom_range(0, 7)) << 2;
      p1 = 32'($urandom_range(0, 7)) << 2;
      n0 = ($urandom_range(0, 7) == 0) ? 32'h0 :
           ($urandom_range(0, 15) == 0) ? HALT_I : 32'h20020000 + 32'($urandom_range(1, 3));
      n1 = ($urandom_range(0, 7) == 0) ? 32'h0 :
           ($urandom_range(0, 15) == 0) ? HALT_I : 32'h20020000 + 32'($urandom_range(1, 3));
      applyStimulus(2'($urandom), p0, n0, p1, n1, 1'($urandom),
                    ($urandom_range(0, 1) == 0) ? HALT_A : 32'h3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
